// File: rtl/riscv_fetch_unit_if.sv
// Fetch unit bundle: instruction-memory request/response, execute redirect,
// and the decode-side valid/ready instruction stream.
interface riscv_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );
endinterface

// File: rtl/riscv_fetch_unit.sv
// RISC-V instruction fetch: single-outstanding request FSM feeding a small
// instruction/PC buffer towards decode, with redirect flush and response discard.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  riscv_fetch_unit_if.master bus
);

  localparam int unsigned      PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Natural 32-bit overflow gives the 0xFFFF_FFFC -> 0x0 wrap.
  function automatic logic [31:0] incr_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             discard_q, discard_d;
  logic [31:0]      req_addr_q;

  logic [31:0]      instr_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem    [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic             flush;
  logic             push;
  logic             pop;
  logic             room_after;
  logic [31:0]      redirect_tgt;

  assign flush        = bus.redirect_valid;
  assign redirect_tgt = align_pc(bus.redirect_pc);

  // A redirect wins over both the decode pop and any response write.
  assign pop  = bus.if_valid & bus.if_ready & ~flush;
  assign push = (state_q == WAIT_RSP) & bus.imem_rvalid & ~discard_q & ~flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign room_after = (count_d < DEPTH_C);

  // ---- buffer control ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // ---- buffer data ----
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.imem_rdata;
      pc_mem[wr_ptr_q]    <= req_addr_q;
    end
  end

  // Address of the single outstanding request, tagged onto its response.
  always_ff @(posedge clk) begin
    if (bus.imem_req & bus.imem_gnt) begin
      req_addr_q <= fetch_pc_q;
    end
  end

  // ---- fetch FSM state ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          fetch_pc_d = redirect_tgt;
          state_d    = WAIT_GNT;
        end else if (count_q < DEPTH_C) begin
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (bus.imem_gnt) begin
          state_d = WAIT_RSP;
          if (flush) begin
            // Request already accepted at the old PC: its data must be dropped.
            fetch_pc_d = redirect_tgt;
            discard_d  = 1'b1;
          end else begin
            fetch_pc_d = incr_pc(fetch_pc_q);
          end
        end else if (flush) begin
          fetch_pc_d = redirect_tgt;
        end
      end
      WAIT_RSP: begin
        if (flush) begin
          fetch_pc_d = redirect_tgt;
        end
        if (bus.imem_rvalid) begin
          discard_d = 1'b0;
          state_d   = room_after ? WAIT_GNT : IDLE;
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_req  = (state_q == WAIT_GNT);
  assign bus.imem_addr = fetch_pc_q;

  // Head is forced to zero when empty so stale storage never leaks out.
  assign bus.if_valid = (count_q != '0);
  assign bus.if_instr = bus.if_valid ? instr_mem[rd_ptr_q] : 32'd0;
  assign bus.if_pc    = bus.if_valid ? pc_mem[rd_ptr_q]    : 32'd0;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: memory responder returning addr>>2 with
// programmable grant/response delays, and hand-computed expected PC/instr streams.
module tb_riscv_fetch_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  riscv_fetch_unit_if bus ();

  riscv_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks    = 0;
  int          failures  = 0;
  int          gnt_delay = 0;
  int          rsp_delay = 0;
  bit          pend      = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          rsp_cnt   = 0;
  int          gwait     = 0;
  int          w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] b2w(input logic b);
    return {31'd0, b};
  endfunction

  // Memory model: one outstanding access, data = address >> 2.
  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (pend && rsp_cnt >= rsp_delay) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = pend_addr >> 2;
        pend            = 1'b0;
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hBAD0_0000;
        if (pend) rsp_cnt++;
      end
      if (bus.imem_req && !pend) begin
        if (gwait >= gnt_delay) begin
          bus.imem_gnt = 1'b1;
          pend         = 1'b1;
          pend_addr    = bus.imem_addr;
          rsp_cnt      = 0;
          gwait        = 0;
        end else begin
          bus.imem_gnt = 1'b0;
          gwait++;
        end
      end else begin
        bus.imem_gnt = 1'b0;
        if (!bus.imem_req) gwait = 0;
      end
    end
  end

  task automatic do_reset(input int gd, input int rd, input logic rdy);
    @(negedge clk);
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.if_ready       = rdy;
    gnt_delay          = gd;
    rsp_delay          = rd;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr, input int budget);
    int n;
    n = 0;
    while (!(bus.imem_req && bus.imem_addr == addr) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, b2w(bus.imem_req), 32'd1);
    chk({tag, "_addr"}, bus.imem_addr, addr);
  endtask

  task automatic expect_pop(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input int budget, output int waited);
    waited = 0;
    while (!bus.if_valid && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_valid"}, b2w(bus.if_valid), 32'd1);
    chk({tag, "_pc"}, bus.if_pc, pc);
    chk({tag, "_instr"}, bus.if_instr, instr);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.if_ready       = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", b2w(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_0000);
    chk("rst_valid", b2w(bus.if_valid), 32'd0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_pc", bus.if_pc, 32'd0);

    // Zero-wait stream: latency 2, then one instruction every 2 cycles.
    reset = 1'b1;
    @(negedge clk);
    chk("t1_first_req", b2w(bus.imem_req), 32'd1);
    chk("t1_first_addr", bus.imem_addr, 32'h0);
    expect_pop("t1_0", 32'h0, 32'd0, 8, w);
    chk("t1_latency", w, 32'd2);
    expect_pop("t1_1", 32'h4, 32'd1, 8, w);
    chk("t1_tput1", w, 32'd1);
    expect_pop("t1_2", 32'h8, 32'd2, 8, w);
    chk("t1_tput2", w, 32'd1);

    // Decode stalled: exactly two buffered, fetch stops, drain in order.
    do_reset(0, 0, 1'b0);
    repeat (10) @(negedge clk);
    chk("t2_req_stopped", b2w(bus.imem_req), 32'd0);
    chk("t2_valid_held", b2w(bus.if_valid), 32'd1);
    chk("t2_pc_held", bus.if_pc, 32'h0);
    @(negedge clk);
    chk("t2_req_still", b2w(bus.imem_req), 32'd0);
    bus.if_ready = 1'b1;
    expect_pop("t2_0", 32'h0, 32'd0, 1, w);
    expect_pop("t2_1", 32'h4, 32'd1, 1, w);
    chk("t2_second_buffered", w, 32'd0);
    expect_pop("t2_2", 32'h8, 32'd2, 8, w);
    chk("t2_third_fetched", w, 32'd2);
    expect_pop("t2_3", 32'hC, 32'd3, 8, w);

    // Redirect with a full buffer: flush, suppressed pop, misaligned target.
    do_reset(0, 0, 1'b0);
    repeat (6) @(negedge clk);
    chk("t2b_full", b2w(bus.if_valid), 32'd1);
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0203;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("t2b_flushed", b2w(bus.if_valid), 32'd0);
    chk("t2b_req", b2w(bus.imem_req), 32'd1);
    chk("t2b_addr", bus.imem_addr, 32'h0000_0200);
    expect_pop("t2b_0", 32'h200, 32'h80, 8, w);

    // Grant delayed 3 cycles: request and address held for 4 cycles.
    do_reset(3, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_req_%0d", i), b2w(bus.imem_req), 32'd1);
      chk($sformatf("t3_addr_%0d", i), bus.imem_addr, 32'h0);
      @(negedge clk);
    end
    chk("t3_req_after_gnt", b2w(bus.imem_req), 32'd0);
    expect_pop("t3_0", 32'h0, 32'd0, 8, w);

    // Redirect while waiting for the 0x8 response: response discarded.
    do_reset(0, 2, 1'b1);
    wait_req("t4_pc8", 32'h8, 40);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("t4_no_req", b2w(bus.imem_req), 32'd0);
    chk("t4_empty", b2w(bus.if_valid), 32'd0);
    wait_req("t4_new", 32'h100, 10);
    chk("t4_dropped", b2w(bus.if_valid), 32'd0);
    expect_pop("t4_0", 32'h100, 32'h40, 12, w);

    // Redirect coincident with rvalid, then PC wrap at the top of memory.
    do_reset(0, 0, 1'b1);
    wait_req("t5_pc4", 32'h4, 10);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("t5_dropped", b2w(bus.if_valid), 32'd0);
    chk("t5_req", b2w(bus.imem_req), 32'd1);
    chk("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
    expect_pop("t5_top", 32'hFFFF_FFFC, 32'h3FFF_FFFF, 8, w);
    expect_pop("t5_wrap", 32'h0, 32'd0, 8, w);

    // Asynchronous reset pulse during WAIT_RSP; stale rvalid arrives later.
    do_reset(0, 3, 1'b0);
    wait_req("t6_pc4", 32'h4, 20);
    @(negedge clk);
    chk("t6_pre_valid", b2w(bus.if_valid), 32'd1);
    chk("t6_pre_addr", bus.imem_addr, 32'h8);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_req", b2w(bus.imem_req), 32'd0);
    chk("t6_async_addr", bus.imem_addr, 32'h0);
    chk("t6_async_valid", b2w(bus.if_valid), 32'd0);
    chk("t6_async_pc", bus.if_pc, 32'd0);
    chk("t6_async_instr", bus.if_instr, 32'd0);
    @(negedge clk);
    reset        = 1'b1;
    bus.if_ready = 1'b1;
    @(negedge clk);
    chk("t6_restart_req", b2w(bus.imem_req), 32'd1);
    chk("t6_restart_addr", bus.imem_addr, 32'h0);
    expect_pop("t6_0", 32'h0, 32'd0, 16, w);
    expect_pop("t6_1", 32'h4, 32'd1, 16, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_unit.md
RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, instruction buffer entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction memory request valid.
REQ-006 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect from execute.
REQ-011 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-012 SHALL have port if_valid  output  1  instruction available to decode.
REQ-013 SHALL have port if_instr  output  32  instruction at FIFO head.
REQ-014 SHALL have port if_pc  output  32  PC of instruction at FIFO head.
REQ-015 SHALL have port if_ready  input  1  decode accepts head this cycle.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RSP.
REQ-017 IDLE -> WAIT_GNT when (FIFO occupancy) < FIFO_DEPTH; imem_req=1 in WAIT_GNT only.
REQ-018 WAIT_GNT: imem_addr = fetch_pc, held stable until imem_gnt=1; on gnt -> WAIT_RSP, fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-019 WAIT_RSP: on imem_rvalid -> write {imem_rdata, request address} into FIFO; next state WAIT_GNT if room remains after write and any same-cycle pop, else IDLE.
REQ-020 SHALL keep at most one outstanding request; imem_rvalid outside WAIT_RSP SHALL be ignored.
REQ-021 Handshake: head popped when if_valid & if_ready; if_valid = FIFO non-empty; if_instr/if_pc unchanged while if_valid & !if_ready.
REQ-022 Full FIFO: no request issued; simultaneous pop and response-write in same cycle SHALL both occur, occupancy unchanged.
REQ-023 Redirect (highest priority): FIFO flushed next cycle (if_valid=0), fetch_pc <= redirect_pc & ~3; any pop in the same cycle is suppressed.
REQ-024 Redirect in WAIT_GNT: next cycle imem_addr = new PC, stays WAIT_GNT (request retargeted, no drop of imem_req).
REQ-025 Redirect in WAIT_RSP (or same cycle as gnt): set discard flag; the pending response SHALL be dropped, not written; then -> WAIT_GNT at new PC.
REQ-026 Redirect coincident with imem_rvalid: response dropped, next state WAIT_GNT at redirect target.
REQ-027 Back-to-back: with zero-wait memory (gnt same cycle as req, rvalid next cycle) and if_ready=1, throughput SHALL be one instruction per 2 cycles; req-to-if_valid latency 2 cycles.

Reset
REQ-028 While reset=0: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, FSM=IDLE, FIFO empty, discard flag clear, fetch_pc=RESET_PC.
REQ-029 Reset assertion mid-request SHALL abandon it immediately (asynchronous); first request after release at RESET_PC, first cycle after reset deasserts.

Verification
REQ-030 Reset release, zero-wait memory returning addr>>2, if_ready=1 -> if_pc sequence 0x0,0x4,0x8, if_instr 0,1,2.
REQ-031 if_ready=0 for 10 cycles -> exactly FIFO_DEPTH (2) entries buffered, imem_req=0, then release yields PCs 0x0,0x4,0x8 in order, none lost or duplicated.
REQ-032 imem_gnt delayed 3 cycles -> imem_req and imem_addr=0x0 held stable for all 4 cycles.
REQ-033 redirect_valid with redirect_pc=0x100 while in WAIT_RSP for 0x8 -> 0x8 response discarded, FIFO empty, next if_pc=0x100.
REQ-034 redirect_pc=0x203 -> first fetch at 0x200; fetch_pc=0xFFFF_FFFC -> next address 0x0.
REQ-035 reset pulse low during WAIT_RSP -> outputs at reset values within same cycle, later stale rvalid ignored, fetch restarts at RESET_PC.
